ram_pipe_sdp: RTL and testbench

Parametrised simple-dual-port RAM with a flow-controlled read path, successor to the fixed-depth M20K wrapper used by the FIFOs. Arbitrary depth, optional same-cycle write-to-read forwarding. Read requests and results use valid/ready handshakes backed by a credit-managed result buffer, so a stalled consumer never corrupts or drops data in flight. Sits under FIFOs, lookup tables and reorder buffers.

---
 rtl/ram_pipe_pkg.sv | 32 +++
 rtl/ram_pipe_core.sv | 79 +++++++
 rtl/ram_pipe_sdp.sv | 151 +++++++++++++++
 tb/tb_ram_pipe_sdp.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pipe_pkg.sv
// ram_pipe_pkg: shared constants, result-entry type and device-family mapping
// for the flow-controlled simple-dual-port RAM (ram_pipe_sdp).
`ifndef RAM_PIPE_PKG_SV
`define RAM_PIPE_PKG_SV

// Result-buffer entry {err, data}; W is the data word width.
`define RAM_PIPE_ENTRY_T(W) struct packed { logic err; logic [(W)-1:0] data; }

package ram_pipe_pkg;

    // Outstanding-read budget; also the depth of the result buffer.
    localparam int CREDITS      = 4;
    // Accept cycle to earliest q_valid cycle.
    localparam int READ_LATENCY = 3;
    localparam int CREDIT_W     = $clog2(CREDITS + 1);
    localparam int BUF_PTR_W    = $clog2(CREDITS);

    typedef enum logic {
        STYLE_M20K  = 1'b0,
        STYLE_LOGIC = 1'b1
    } ramstyle_e;

    // Intel families with M20K blocks get a block-RAM style, anything else fabric.
    function automatic ramstyle_e family_ramstyle(input string family);
        if (family == "Agilex" || family == "S10" || family == "A10")
            return STYLE_M20K;
        return STYLE_LOGIC;
    endfunction

endpackage

`endif

// File: rtl/ram_pipe_core.sv
// ram_pipe_core: bare storage array with a free-running 2-stage read pipeline
// (registered address, registered output) and a matching valid sideband.
// Read-during-write on the same address is left undefined here; the top
// decides whether to forward.
module ram_pipe_core
    import ram_pipe_pkg::*;
#(
    parameter int    WIDTH      = 32,
    parameter int    DEPTH      = 1024,
    parameter int    ADDR_WIDTH = $clog2(DEPTH),
    parameter string FAMILY     = "Agilex"
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_vld,
    output logic [WIDTH-1:0]      rd_data
);

    localparam ramstyle_e STYLE = family_ramstyle(FAMILY);

    logic [ADDR_WIDTH-1:0] addr_p0;
    logic                  vld_p0;
    logic                  vld_p1;
    logic [WIDTH-1:0]      data_p1;

    // Valid sideband follows the read stages; the only state cleared by reset.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= rd_en;
            vld_p1 <= vld_p0;
        end
    end

    // ---- stage p0: address register (always advances) ----
    always_ff @(posedge clk) begin
        addr_p0 <= rd_addr;
    end

    // ---- stage p1: array read into output register ----
    generate
        if (STYLE == STYLE_M20K) begin : g_m20k
            (* ramstyle = "M20K" *) logic [WIDTH-1:0] mem [DEPTH];

            // Write port.
            always_ff @(posedge clk) begin
                if (wr_en) mem[wr_addr] <= wr_data;
            end

            // Output register.
            always_ff @(posedge clk) begin
                data_p1 <= mem[addr_p0];
            end
        end else begin : g_logic
            (* ramstyle = "logic" *) logic [WIDTH-1:0] mem [DEPTH];

            // Write port.
            always_ff @(posedge clk) begin
                if (wr_en) mem[wr_addr] <= wr_data;
            end

            // Output register.
            always_ff @(posedge clk) begin
                data_p1 <= mem[addr_p0];
            end
        end
    endgenerate

    assign rd_vld  = vld_p1;
    assign rd_data = data_p1;

endmodule

// File: rtl/ram_pipe_sdp.sv
// ram_pipe_sdp: simple-dual-port RAM with a credit-managed, valid/ready read
// path. Requests are accepted only while a result slot is guaranteed, so the
// 4-entry result buffer can never overflow and a stalled consumer loses nothing.
// Optional feature macro: RAM_PIPE_SDP_FWD_EN forwards a same-address write
// issued in the read's accept cycle to that read.
module ram_pipe_sdp
    import ram_pipe_pkg::*;
#(
    parameter int    WIDTH      = 32,
    parameter int    DEPTH      = 1024,
    parameter int    ADDR_WIDTH = $clog2(DEPTH),
    parameter string FAMILY     = "Agilex"
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  q_valid,
    input  logic                  q_ready,
    output logic [WIDTH-1:0]      q_data,
    output logic                  q_err
);

    typedef `RAM_PIPE_ENTRY_T(WIDTH) entry_t;

    logic                  wr_ok;
    logic                  rd_ok;
    logic                  accept;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] core_rd_addr;
    logic                  core_vld;
    logic [WIDTH-1:0]      core_data;

    logic                  err_p0;
    logic                  err_p1;
    entry_t                push_entry;

    logic [CREDIT_W-1:0]   credit_cnt;
    logic [CREDIT_W-1:0]   credit_nxt;

    entry_t                buf_mem [CREDITS];
    logic [BUF_PTR_W-1:0]  wptr;
    logic [BUF_PTR_W-1:0]  rptr;
    logic [CREDIT_W-1:0]   count;

    // Depth need not be a power of two, so both ports range-check the address.
    assign wr_ok  = int'(wr_addr) < DEPTH;
    assign rd_ok  = int'(rd_addr) < DEPTH;
    assign accept = rd_valid & rd_ready;
    assign pop    = q_valid & q_ready;

    // Out-of-range reads still walk the pipeline (to keep order) but at a safe index.
    assign core_rd_addr = rd_ok ? rd_addr : '0;

    ram_pipe_core #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .FAMILY     (FAMILY)
    ) u_core (
        .clk     (clk),
        .arst    (arst),
        .wr_en   (wr_en & wr_ok),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (accept),
        .rd_addr (core_rd_addr),
        .rd_vld  (core_vld),
        .rd_data (core_data)
    );

    // ---- stage p0 / p1: range-error sideband aligned with the core read ----
    // Sideband data travels unconditionally; the core valid qualifies it.
    always_ff @(posedge clk) begin
        err_p0 <= ~rd_ok;
        err_p1 <= err_p0;
    end

`ifdef RAM_PIPE_SDP_FWD_EN
    logic             fwd_p0;
    logic             fwd_p1;
    logic [WIDTH-1:0] fwd_data_p0;
    logic [WIDTH-1:0] fwd_data_p1;

    // Capture a same-cycle, same-address, in-range write next to the read address.
    always_ff @(posedge clk) begin
        fwd_p0      <= wr_en & wr_ok & (wr_addr == rd_addr);
        fwd_data_p0 <= wr_data;
        fwd_p1      <= fwd_p0;
        fwd_data_p1 <= fwd_data_p0;
    end

    // Build the buffer entry: range error wins, then forwarded write, then array.
    always_comb begin
        push_entry.err  = err_p1;
        push_entry.data = '0;
        if (!err_p1) push_entry.data = fwd_p1 ? fwd_data_p1 : core_data;
    end
`else
    // Build the buffer entry: range error reads as zero data.
    always_comb begin
        push_entry.err  = err_p1;
        push_entry.data = '0;
        if (!err_p1) push_entry.data = core_data;
    end
`endif

    // ---- stage p2: result buffer ----
    // Entry storage; no reset needed since occupancy qualifies it.
    always_ff @(posedge clk) begin
        if (core_vld) buf_mem[wptr] <= push_entry;
    end

    // Buffer pointers and occupancy.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (core_vld) wptr <= wptr + BUF_PTR_W'(1);
            if (pop)      rptr <= rptr + BUF_PTR_W'(1);
            count <= count + CREDIT_W'(core_vld) - CREDIT_W'(pop);
        end
    end

    assign q_valid = (count != '0);
    assign q_data  = q_valid ? buf_mem[rptr].data : '0;
    assign q_err   = q_valid & buf_mem[rptr].err;

    // Credits: one per accepted request, returned when its result is popped.
    always_comb begin
        credit_nxt = credit_cnt - CREDIT_W'(accept) + CREDIT_W'(pop);
    end

    // Credit register and registered rd_ready (held low during reset).
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            credit_cnt <= CREDIT_W'(CREDITS);
            rd_ready   <= 1'b0;
        end else begin
            credit_cnt <= credit_nxt;
            rd_ready   <= (credit_nxt != '0);
        end
    end

endmodule

// File: tb/tb_ram_pipe_sdp.sv
// tb_ram_pipe_sdp: randomized and directed bench for ram_pipe_sdp (DEPTH=1000)
// against a word-array memory model and an in-order result scoreboard.
module tb_ram_pipe_sdp;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 1000;
    localparam int AW      = 10;
    localparam int CREDITS = 4;

    logic             clk;
    logic             arst;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [AW-1:0]    rd_addr;
    logic             q_valid;
    logic             q_ready;
    logic [WIDTH-1:0] q_data;
    logic             q_err;

    ram_pipe_sdp #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .FAMILY     ("Agilex")
    ) dut (
        .clk      (clk),
        .arst     (arst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_addr  (rd_addr),
        .q_valid  (q_valid),
        .q_ready  (q_ready),
        .q_data   (q_data),
        .q_err    (q_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             err;
        bit               chk;
        int               cyc;
    } exp_t;

    logic [WIDTH-1:0] model [DEPTH];
    exp_t             sb [$];
    int               outstanding;
    int               cyc;
    int               n_checks;
    int               n_fail;
    bit               in_reset;
    bit               last_acc;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: inputs are already driven; evaluate at the falling edge.
    task automatic cycle();
        exp_t e;
        #4;
        last_acc = 1'b0;
        if (in_reset) begin
            check_eq("rst_rd_ready", rd_ready, 0);
            check_eq("rst_q_valid", q_valid, 0);
            check_eq("rst_q_data", q_data, 0);
            check_eq("rst_q_err", q_err, 0);
        end else begin
            check_eq("rd_ready_credit", rd_ready, outstanding < CREDITS);
            if (sb.size() == 0)
                check_eq("no_spurious_q_valid", q_valid, 0);
            else if (cyc - sb[0].cyc >= 3)
                check_eq("q_valid_due", q_valid, 1);
            if (q_valid && q_ready && sb.size() != 0) begin
                e = sb.pop_front();
                check_eq("latency_min", (cyc - e.cyc) >= 3, 1);
                check_eq("q_err", q_err, e.err);
                if (e.chk) check_eq("q_data", q_data, e.data);
                outstanding--;
            end
            if (rd_valid && rd_ready) begin
                last_acc = 1'b1;
                e.cyc = cyc;
                e.chk = 1'b1;
                e.err = 1'b0;
                e.data = '0;
                if (int'(rd_addr) >= DEPTH) begin
                    e.err = 1'b1;
                end else if (wr_en && wr_addr == rd_addr) begin
`ifdef RAM_PIPE_SDP_FWD_EN
                    e.data = wr_data;
`else
                    e.chk = 1'b0;
`endif
                end else begin
                    e.data = model[rd_addr];
                end
                sb.push_back(e);
                outstanding++;
            end
            if (wr_en && int'(wr_addr) < DEPTH) model[wr_addr] = wr_data;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; rd_valid = 1'b0; q_ready = 1'b1;
    endtask

    // Pop everything outstanding with a bounded wait.
    task automatic drain();
        int n;
        idle_inputs();
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            cycle();
            n++;
        end
        check_eq("drain_empty", sb.size(), 0);
    endtask

    task automatic write_word(input int a, input logic [WIDTH-1:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    endtask

    initial begin
        int n;
        int nacc;
        int idx;
        logic [AW-1:0] bp_addr [6];

        n_checks = 0; n_fail = 0; cyc = 0; outstanding = 0;
        arst = 1'b1; in_reset = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_valid = 1'b0; rd_addr = '0; q_ready = 1'b0;
        @(posedge clk); #1;
        cycle(); cycle();
        arst = 1'b0;
        cycle();
        in_reset = 1'b0;

        // Preload every word so the model is fully known.
        q_ready = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            write_word(a, $urandom);
            cycle();
        end
        wr_en = 1'b0;

        // Write then read in the next cycle: exact latency and data.
        write_word(5, 32'hA5A5_0001);
        cycle();
        wr_en = 1'b0; rd_valid = 1'b1; rd_addr = AW'(5); q_ready = 1'b1;
        cycle();
        rd_valid = 1'b0;
        n = 1;
        while (!q_valid && n < 10) begin
            cycle();
            n++;
        end
        check_eq("rd5_latency", n, 3);
        check_eq("rd5_data", q_data, 32'hA5A5_0001);
        check_eq("rd5_err", q_err, 0);
        drain();

        // Backpressure: six held requests, only four credits.
        for (int i = 0; i < 6; i++) bp_addr[i] = AW'(10 + i * 7);
        q_ready = 1'b0; idx = 0; nacc = 0;
        for (int i = 0; i < 8; i++) begin
            rd_valid = 1'b1; rd_addr = bp_addr[idx];
            cycle();
            if (last_acc) begin idx++; nacc++; end
        end
        check_eq("bp_accepts", nacc, 4);
        check_eq("bp_rd_ready_low", rd_ready, 0);
        q_ready = 1'b1; n = 0;
        while (idx < 6 && n < 30) begin
            rd_valid = 1'b1; rd_addr = bp_addr[idx];
            cycle();
            if (last_acc) idx++;
            n++;
        end
        check_eq("bp_all_accepted", idx, 6);
        drain();

        // Out-of-range write is dropped; out-of-range read flags err with zero data.
        write_word(1005, 32'hDEAD_BEEF);
        cycle();
        wr_en = 1'b0; rd_valid = 1'b1; rd_addr = AW'(1005);
        cycle();
        rd_addr = AW'(5);   cycle();
        rd_addr = AW'(493); cycle();
        rd_valid = 1'b0;
        n = 0;
        while (!(q_valid && q_err) && n < 10) begin cycle(); n++; end
        check_eq("oor_err", q_err, 1);
        check_eq("oor_data", q_data, 0);
        drain();

`ifdef RAM_PIPE_SDP_FWD_EN
        // Same-cycle write forwards; write one cycle later is not seen.
        write_word(7, 32'h11);
        cycle();
        write_word(7, 32'h22); rd_valid = 1'b1; rd_addr = AW'(7);
        cycle();
        rd_valid = 1'b0; write_word(7, 32'h33);
        cycle();
        wr_en = 1'b0;
        n = 0;
        while (!q_valid && n < 10) begin cycle(); n++; end
        check_eq("fwd_data", q_data, 32'h22);
        drain();
`endif

        // Randomized traffic with random consumer stalls.
        for (int i = 0; i < 10000; i++) begin
            wr_en    = ($urandom_range(0, 1) == 1);
            wr_addr  = AW'($urandom_range(0, 1023));
            wr_data  = $urandom;
            rd_valid = ($urandom_range(0, 2) != 0);
            rd_addr  = ($urandom_range(0, 7) == 0) ? wr_addr : AW'($urandom_range(0, 1023));
            q_ready  = ($urandom_range(0, 2) != 0);
            cycle();
        end
        drain();

        // Reset with three reads in flight: nothing stale may emerge.
        q_ready = 1'b0; rd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_addr = AW'(20 + i);
            cycle();
        end
        rd_valid = 1'b0;
        arst = 1'b1; in_reset = 1'b1;
        sb.delete(); outstanding = 0;
        cycle(); cycle();
        arst = 1'b0;
        cycle();
        in_reset = 1'b0;
        check_eq("post_rst_rd_ready", rd_ready, 1);
        q_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        check_eq("post_rst_q_valid", q_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
